gpc_mem_responder: RTL and testbench

- Memory-side responder for the GPC register/program memory handshake (adrs, mode, erase, data, out).
- The controller drives the handshake:
  - Read: set adrs, wait 2 cycles, take out.
  - Write: set adrs/data, hold mode high for 3 cycles.
  - Erase: pulse erase.
- This block stores DEPTH bytes, filters the write strobe, sweeps the array on erase, and reports busy/wr_done back to the controller.

---
 rtl/gpc_mem_responder.sv | 165 ++++++++++++++++
 tb/tb_gpc_mem_responder.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/gpc_mem_responder.sv
// Memory-side responder for the GPC adrs/mode/erase handshake: byte array, filtered write strobe, erase sweep.
// Optional even-parity storage and checking is enabled by defining GPC_MEM_PARITY_EN.
module gpc_mem_responder #(
    parameter int ADDR_W = 6,
    parameter int DEPTH  = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] adrs,
    input  logic              mode,
    input  logic              erase,
    input  logic [7:0]        data,
    output logic [7:0]        out,
    output logic              busy,
    output logic              wr_done,
    output logic              par_err
);

`ifdef GPC_MEM_PARITY_EN
    localparam int WORD_W = 9;
`else
    localparam int WORD_W = 8;
`endif

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ARM      = 2'd1,
        WAIT_LOW = 2'd2,
        ERASE    = 2'd3
    } state_t;

    state_t state, state_d;

    logic [WORD_W-1:0] mem [DEPTH];
    logic [WORD_W-1:0] rd_word;
    logic [WORD_W-1:0] wd;
    logic [ADDR_W-1:0] wa;
    logic [ADDR_W-1:0] ptr, ptr_d;
    logic [ADDR_W-1:0] adrs_q;
    logic [ADDR_W-1:0] lat_adrs;
    logic [7:0]        lat_data;
    logic              mode_q, erase_q;
    logic              mode_rise, erase_rise;
    logic              latch_en, we, wr_done_d;

    assign mode_rise  = mode & ~mode_q;
    assign erase_rise = erase & ~erase_q;
    assign rd_word    = mem[adrs_q];

    // Stored word for a controller write; the parity build appends the even-parity bit.
    function automatic logic [WORD_W-1:0] encode(input logic [7:0] d);
`ifdef GPC_MEM_PARITY_EN
        return {^d, d};
`else
        return d;
`endif
    endfunction

    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        state_d   = state;
        ptr_d     = ptr;
        latch_en  = 1'b0;
        we        = 1'b0;
        wa        = lat_adrs;
        wd        = encode(lat_data);
        wr_done_d = 1'b0;

        case (state)
            IDLE: begin
                if (erase_rise) begin
                    state_d = ERASE;
                    ptr_d   = '0;
                end else if (mode_rise) begin
                    latch_en = 1'b1;
                    state_d  = ARM;
                end
            end
            ARM: begin
                if (erase_rise) begin
                    state_d = ERASE;
                    ptr_d   = '0;
                end else if (mode) begin
                    we        = 1'b1;
                    wr_done_d = 1'b1;
                    state_d   = WAIT_LOW;
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT_LOW: begin
                if (erase_rise) begin
                    state_d = ERASE;
                    ptr_d   = '0;
                end else if (!mode) begin
                    state_d = IDLE;
                end
            end
            ERASE: begin
                // Strobe edges are ignored; the sweep always runs to completion.
                we    = 1'b1;
                wa    = ptr;
                wd    = '0;
                ptr_d = ptr + 1'b1;
                if (ptr == ADDR_W'(DEPTH - 1)) begin
                    state_d = mode ? WAIT_LOW : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state   <= IDLE;
            mode_q  <= 1'b0;
            erase_q <= 1'b0;
            ptr     <= '0;
            adrs_q  <= '0;
            busy    <= 1'b0;
            wr_done <= 1'b0;
            out     <= 8'h00;
        end else begin
            state   <= state_d;
            mode_q  <= mode;
            erase_q <= erase;
            ptr     <= ptr_d;
            adrs_q  <= adrs;
            busy    <= (state_d == ERASE);
            wr_done <= wr_done_d;
            out     <= (state_d == ERASE) ? 8'h00 : rd_word[7:0];
        end
    end

    // Write latch only captures on the accepted mode rise.
    always_ff @(posedge clk) begin
        if (latch_en) begin
            lat_adrs <= adrs;
            lat_data <= data;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: the array has no reset; rst only blocks a write on the same edge.
        if (we && !rst) begin
            mem[wa] <= wd;
        end
    end

`ifdef GPC_MEM_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            par_err <= 1'b0;
        end else if (state_d == ERASE) begin
            par_err <= 1'b0;
        end else begin
            par_err <= (^rd_word[7:0]) != rd_word[8];
        end
    end
`else
    assign par_err = 1'b0;
`endif

endmodule

// File: tb/tb_gpc_mem_responder.sv
// Self-checking bench for gpc_mem_responder: directed stimulus feeds expectation queues,
// a negedge monitor compares read data, parity flag and wr_done timing against them.
module tb_gpc_mem_responder;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] adrs;
    logic       mode;
    logic       erase;
    logic [7:0] data;
    logic [7:0] out;
    logic       busy;
    logic       wr_done;
    logic       par_err;

    gpc_mem_responder #(.ADDR_W(6), .DEPTH(64)) dut (
        .clk     (clk),
        .rst     (rst),
        .adrs    (adrs),
        .mode    (mode),
        .erase   (erase),
        .data    (data),
        .out     (out),
        .busy    (busy),
        .wr_done (wr_done),
        .par_err (par_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         stamp;
        logic [7:0] data;
        logic       par;
    } rd_t;

    rd_t rd_q[$];
    int  wr_q[$];
    int  cyc = 0;
    int  n_checks = 0;
    int  n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: presents each queued expectation at the cycle its output is due.
    always @(negedge clk) begin
        if (rd_q.size() > 0 && rd_q[0].stamp == cyc) begin
            rd_t e;
            e = rd_q.pop_front();
            check("rd_out", 32'(out), 32'(e.data));
            check("rd_par_err", 32'(par_err), 32'(e.par));
        end
        if (wr_done) begin
            if (wr_q.size() > 0) begin
                int s;
                s = wr_q.pop_front();
                check("wr_done_cycle", cyc, s);
            end else begin
                check("wr_done_unexpected", 32'(wr_done), 32'd0);
            end
        end else if (wr_q.size() > 0 && wr_q[0] <= cyc) begin
            void'(wr_q.pop_front());
            check("wr_done_missing", 32'(wr_done), 32'd1);
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Mode held for n sampled edges; data switches to d_late after the third cycle.
    task automatic wr(input logic [5:0] a, input logic [7:0] d, input int n, input logic [7:0] d_late);
        @(negedge clk);
        adrs = a;
        data = d;
        mode = 1'b1;
        if (n >= 2) wr_q.push_back(cyc + 2);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (i == 2) data = d_late;
        end
        mode = 1'b0;
    endtask

    task automatic rd(input logic [5:0] a, input logic [7:0] exp, input logic par);
        rd_t e;
        @(negedge clk);
        adrs = a;
        e.stamp = cyc + 2;
        e.data  = exp;
        e.par   = par;
        rd_q.push_back(e);
    endtask

    task automatic erase_pulse();
        @(negedge clk);
        erase = 1'b1;
        @(negedge clk);
        erase = 1'b0;
    endtask

    task automatic wait_sweep_done();
        int n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("sweep_terminates", 32'(busy), 32'd0);
    endtask

    initial begin
        int   n;
        int   bad;
        rd_t  e;

        rst = 1'b1; adrs = '0; mode = 1'b0; erase = 1'b0; data = '0;
        idle(3);
        check("rst_out", 32'(out), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_wr_done", 32'(wr_done), 32'd0);
        check("rst_par_err", 32'(par_err), 32'd0);
        rst = 1'b0;

        erase_pulse();
        check("erase_busy_rise", 32'(busy), 32'd1);
        wait_sweep_done();

        // Basic write then read, followed by read-during-write on the same address.
        wr(6'd5, 8'hA5, 3, 8'hA5);
        rd(6'd5, 8'hA5, 1'b0);
        idle(2);
        @(negedge clk);
        adrs = 6'd5; data = 8'h66; mode = 1'b1;
        wr_q.push_back(cyc + 2);
        e.stamp = cyc + 2; e.data = 8'hA5; e.par = 1'b0; rd_q.push_back(e);
        e.stamp = cyc + 3; e.data = 8'h66; e.par = 1'b0; rd_q.push_back(e);
        idle(3);
        mode = 1'b0;
        idle(2);

        // One-cycle glitch must not write.
        wr(6'd7, 8'h3C, 1, 8'h3C);
        rd(6'd7, 8'h00, 1'b0);

        // Long strobe commits the data latched at the first sample only.
        wr(6'd9, 8'h11, 10, 8'h22);
        rd(6'd9, 8'h11, 1'b0);
        idle(2);

`ifdef GPC_MEM_PARITY_EN
        wr(6'd3, 8'h5A, 2, 8'h5A);
        rd(6'd3, 8'h5A, 1'b0);
        idle(2);
        dut.mem[3] = dut.mem[3] ^ 9'h001;
        rd(6'd3, 8'h5B, 1'b1);
        idle(2);
`endif

        // Erase sweep: 64 busy cycles, out held at 0, mode pulse ignored.
        wr(6'd0, 8'h11, 2, 8'h11);
        wr(6'd63, 8'h11, 2, 8'h11);
        rd(6'd63, 8'h11, 1'b0);
        rd(6'd0, 8'h11, 1'b0);
        idle(3);
        erase_pulse();
        n = 0; bad = 0;
        while (busy && n < 200) begin
            if (out !== 8'h00) bad++;
            if (n == 10) begin adrs = 6'd0; data = 8'h77; mode = 1'b1; end
            if (n == 13) mode = 1'b0;
            n++;
            @(negedge clk);
        end
        check("sweep_busy_cycles", n, 64);
        check("sweep_out_zero", bad, 0);
        rd(6'd0, 8'h00, 1'b0);
        rd(6'd63, 8'h00, 1'b0);
        idle(3);

        // Reset at sweep cycle 20 aborts the sweep.
        for (int i = 0; i < 64; i++) wr(6'(i), 8'hFF, 2, 8'hFF);
        idle(2);
        erase_pulse();
        repeat (20) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_out", 32'(out), 32'd0);
        rst = 1'b0;
        rd(6'd0, 8'h00, 1'b0);
        rd(6'd19, 8'h00, 1'b0);
        rd(6'd30, 8'hFF, 1'b0);
        rd(6'd63, 8'hFF, 1'b0);
        idle(5);

        check("rd_queue_drained", rd_q.size(), 0);
        check("wr_queue_drained", wr_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
